alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU request arbiter: ALU opcodes, FSM states and opcode legality.
package alu_arb_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESPOND   = 2'd3
   } state_e;

   // no_op, rst_op and the unused encodings never reach the ALU
   function automatic logic op_legal(input logic [2:0] op);
      case (op)
         add_op, and_op, xor_op, mul_op: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, one-hot result.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W:0] idx;
   logic           found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
         if (!found && req[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters, one command in flight, with timeout and error response.
//   state     | meaning
//   IDLE      | arbitrate, grant and latch the winner's command
//   ISSUE     | drive the latched command until the ALU accepts it
//   WAIT_DONE | wait for alu_done, bounded by TIMEOUT cycles from issue
//   RESPOND   | one-cycle response pulse to the winner
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int OP_WIDTH     = 8,
   parameter int RESULT_WIDTH = OP_WIDTH + 1,
   parameter int NUM_REQ      = 4,
   parameter int TIMEOUT      = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*3-1:0]        req_op,
   input  logic [NUM_REQ*OP_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*OP_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]          req_grant,
   output logic                        alu_valid,
   output logic [2:0]                  alu_op,
   output logic [OP_WIDTH-1:0]         alu_a,
   output logic [OP_WIDTH-1:0]         alu_b,
   input  logic                        alu_ready,
   input  logic                        alu_done,
   input  logic [RESULT_WIDTH-1:0]     alu_result,
   output logic                        rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [RESULT_WIDTH-1:0]     rsp_result,
   output logic                        rsp_err,
   output logic                        busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e                  state, state_nxt;
   logic [ID_W-1:0]         ptr, id_q, win_id;
   logic [2:0]              op_q, win_op;
   logic [OP_WIDTH-1:0]     a_q, b_q, win_a, win_b;
   logic [RESULT_WIDTH-1:0] result_q;
   logic                    err_q;
   logic [CNT_W-1:0]        cnt;
   logic [NUM_REQ-1:0]      rr_grant;
   logic                    any_req, timed_out;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (rr_grant)
   );

   assign any_req = |req_valid;
   // down-counter loaded at issue; terminal value 1 puts RESPOND exactly TIMEOUT cycles after issue
   assign timed_out = (cnt == CNT_W'(1));

   always_comb begin
      win_id = '0;
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rr_grant[i]) begin
            win_id = ID_W'(i);
            win_op = req_op[3*i +: 3];
            win_a  = req_a[OP_WIDTH*i +: OP_WIDTH];
            win_b  = req_b[OP_WIDTH*i +: OP_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (any_req) state_nxt = op_legal(win_op) ? ISSUE : RESPOND;
         ISSUE:     if (alu_ready) state_nxt = WAIT_DONE;
         WAIT_DONE: if (alu_done || timed_out) state_nxt = RESPOND;
         RESPOND:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         id_q     <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               id_q     <= win_id;
               op_q     <= win_op;
               a_q      <= win_a;
               b_q      <= win_b;
               ptr      <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
               err_q    <= !op_legal(win_op);
               result_q <= '0;
            end
            ISSUE: if (alu_ready) cnt <= CNT_W'(TIMEOUT-1);
            // alu_done is checked first so a completion on the terminal cycle still wins
            WAIT_DONE: begin
               if (alu_done) begin
                  result_q <= alu_result;
                  err_q    <= 1'b0;
               end else if (timed_out) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_grant  = (state == IDLE && !rst) ? rr_grant : '0;
   assign alu_valid  = (state == ISSUE) && alu_ready;
   assign alu_op     = alu_valid ? op_q : 3'b000;
   assign alu_a      = alu_valid ? a_q : '0;
   assign alu_b      = alu_valid ? b_q : '0;
   assign rsp_valid  = (state == RESPOND);
   assign rsp_id     = rsp_valid ? id_q : '0;
   assign rsp_result = rsp_valid ? result_q : '0;
   assign rsp_err    = rsp_valid && err_q;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scenario bench for alu_req_arbiter; expected responses queue up at grant and are matched at rsp_valid.
module tb_alu_req_arbiter;

   localparam int OP_WIDTH     = 8;
   localparam int RESULT_WIDTH = 9;
   localparam int NUM_REQ      = 4;
   localparam int TIMEOUT      = 32;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*3-1:0]        req_op;
   logic [NUM_REQ*OP_WIDTH-1:0] req_a, req_b;
   logic [NUM_REQ-1:0]          req_grant;
   logic                        alu_valid;
   logic [2:0]                  alu_op;
   logic [OP_WIDTH-1:0]         alu_a, alu_b;
   logic                        alu_ready, alu_done;
   logic [RESULT_WIDTH-1:0]     alu_result;
   logic                        rsp_valid;
   logic [1:0]                  rsp_id;
   logic [RESULT_WIDTH-1:0]     rsp_result;
   logic                        rsp_err, busy;

   int checks = 0;
   int errors = 0;
   int alu_issues = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [8:0] res;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   alu_req_arbiter #(
      .OP_WIDTH(OP_WIDTH), .RESULT_WIDTH(RESULT_WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_grant(req_grant), .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ready(alu_ready), .alu_done(alu_done), .alu_result(alu_result), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (op)
         3'b001:  return {1'b0, a} + {1'b0, b};
         3'b010:  return {1'b0, a & b};
         3'b011:  return {1'b0, a ^ b};
         3'b100:  return p[8:0];
         default: return 9'h000;
      endcase
   endfunction

   // response scoreboard plus always-on protocol checks
   always @(negedge clk) begin
      if (!rst) begin
         if (alu_valid) alu_issues++;
         checks++;
         if (!alu_valid && (alu_op != 3'b000 || alu_a != 8'h00 || alu_b != 8'h00)) begin
            errors++;
            $display("FAIL alu_idle_zero op=%0h a=%0h b=%0h expected all 0", alu_op, alu_a, alu_b);
         end
         if (req_grant != '0) begin
            checks++;
            if (busy !== 1'b0 || $countones(req_grant) != 1) begin
               errors++;
               $display("FAIL grant_in_idle grant=%b busy=%b expected one-hot with busy 0", req_grant, busy);
            end
         end
         if (rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rsp id=%0d result=%0h err=%b expected none", rsp_id, rsp_result, rsp_err);
            end else begin
               mon_e = sb.pop_front();
               if (rsp_id !== mon_e.id || rsp_result !== mon_e.res || rsp_err !== mon_e.err) begin
                  errors++;
                  $display("FAIL rsp got id=%0d res=%0h err=%b expected id=%0d res=%0h err=%b",
                           rsp_id, rsp_result, rsp_err, mon_e.id, mon_e.res, mon_e.err);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   task automatic wait_grant(output logic [3:0] g);
      g = '0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_grant != '0) begin
            g = req_grant;
            return;
         end
      end
   endtask

   task automatic wait_alu(output bit seen);
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (alu_valid) begin
            seen = 1'b1;
            return;
         end
      end
   endtask

   task automatic alu_complete(input logic [8:0] r);
      tick();
      alu_done   = 1'b1;
      alu_result = r;
      tick();
      alu_done   = 1'b0;
      alu_result = '0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 20; n++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'b001, 8'(i + 1), 8'h20);
      req_valid = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_grant, alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs grant=%b av=%b op=%0h a=%0h b=%0h rv=%b id=%0d res=%0h err=%b busy=%b expected all 0",
                  req_grant, alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err, busy);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0] g;
      bit         seen;
      int         e;
      for (int n = 0; n < 5; n++) begin
         e = n % NUM_REQ;
         wait_grant(g);
         checks++;
         if (g !== 4'(1 << e)) begin
            errors++;
            $display("FAIL rr_grant n=%0d got %b expected %b", n, g, 4'(1 << e));
         end
         sb.push_back('{id: 2'(e), res: alu_model(3'b001, 8'(e + 1), 8'h20), err: 1'b0});
         if (n == 4) begin
            tick();
            req_valid = '0;
         end
         wait_alu(seen);
         checks++;
         if (!seen || alu_a !== 8'(e + 1) || alu_b !== 8'h20) begin
            errors++;
            $display("FAIL rr_issue n=%0d seen=%b a=%0h b=%0h expected a=%0h b=20", n, seen, alu_a, alu_b, 8'(e + 1));
         end
         alu_complete(alu_model(3'b001, 8'(e + 1), 8'h20));
      end
      wait_drain();
   endtask

   task automatic test_add_overflow();
      logic [3:0] g;
      tick();
      set_req(2, 3'b001, 8'hFF, 8'h01);
      req_valid = 4'b0100;
      wait_grant(g);
      checks++;
      if (g !== 4'b0100) begin
         errors++;
         $display("FAIL add_grant got %b expected 0100", g);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b1 || alu_op !== 3'b001 || alu_a !== 8'hFF || alu_b !== 8'h01) begin
         errors++;
         $display("FAIL add_issue av=%b op=%0h a=%0h b=%0h expected 1/1/ff/01", alu_valid, alu_op, alu_a, alu_b);
      end
      sb.push_back('{id: 2'd2, res: 9'h100, err: 1'b0});
      tick();
      alu_done   = 1'b1;
      alu_result = alu_model(3'b001, 8'hFF, 8'h01);
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_one_shot av=%b rv=%b expected 0/0", alu_valid, rsp_valid);
      end
      tick();
      alu_done   = 1'b0;
      alu_result = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL add_rsp_latency rv=%b expected 1", rsp_valid);
      end
      wait_drain();
   endtask

   task automatic test_illegal_op();
      logic [3:0] g;
      int         issues0;
      tick();
      set_req(1, 3'b111, 8'h33, 8'h44);
      req_valid = 4'b0010;
      issues0   = alu_issues;
      wait_grant(g);
      checks++;
      if (g !== 4'b0010) begin
         errors++;
         $display("FAIL illegal_grant got %b expected 0010", g);
      end
      sb.push_back('{id: 2'd1, res: 9'h000, err: 1'b1});
      tick();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 9'h000) begin
         errors++;
         $display("FAIL illegal_rsp rv=%b err=%b res=%0h expected 1/1/0", rsp_valid, rsp_err, rsp_result);
      end
      tick();
      @(negedge clk);
      tick();
      checks++;
      if (busy !== 1'b0 || alu_issues != issues0) begin
         errors++;
         $display("FAIL illegal_no_alu busy=%b issues=%0d expected 0/%0d", busy, alu_issues, issues0);
      end
      wait_drain();
   endtask

   task automatic test_ready_stall();
      logic [3:0] g;
      tick();
      alu_ready = 1'b0;
      set_req(3, 3'b011, 8'h5A, 8'hFF);
      req_valid = 4'b1000;
      wait_grant(g);
      checks++;
      if (g !== 4'b1000) begin
         errors++;
         $display("FAIL stall_grant got %b expected 1000", g);
      end
      tick();
      req_valid = '0;
      for (int k = 1; k <= 10; k++) begin
         alu_done   = (k == 5);
         alu_result = (k == 5) ? 9'h1FF : 9'h000;
         @(negedge clk);
         checks++;
         if (alu_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold k=%0d av=%b busy=%b expected 0/1", k, alu_valid, busy);
         end
         tick();
      end
      alu_done   = 1'b0;
      alu_result = '0;
      alu_ready  = 1'b1;
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b1 || alu_op !== 3'b011 || alu_a !== 8'h5A || alu_b !== 8'hFF) begin
         errors++;
         $display("FAIL stall_issue av=%b op=%0h a=%0h b=%0h expected 1/3/5a/ff", alu_valid, alu_op, alu_a, alu_b);
      end
      sb.push_back('{id: 2'd3, res: 9'h0A5, err: 1'b0});
      alu_complete(alu_model(3'b011, 8'h5A, 8'hFF));
      wait_drain();
      // a completion pulse with nothing in flight must be ignored
      tick();
      alu_done   = 1'b1;
      alu_result = 9'h1FF;
      tick();
      alu_done   = 1'b0;
      alu_result = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_done rv=%b busy=%b expected 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] g;
      bit         seen;
      bit         early;
      tick();
      set_req(0, 3'b010, 8'hF0, 8'h3C);
      req_valid = 4'b0001;
      wait_grant(g);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("FAIL to_grant got %b expected 0001", g);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (alu_valid !== 1'b1) begin
         errors++;
         $display("FAIL to_issue av=%b expected 1", alu_valid);
      end
      sb.push_back('{id: 2'd0, res: 9'h000, err: 1'b1});
      early = 1'b0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         @(negedge clk);
         if (k < TIMEOUT) begin
            if (rsp_valid) early = 1'b1;
         end else begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
               errors++;
               $display("FAIL to_rsp rv=%b err=%b expected 1/1 at issue+%0d", rsp_valid, rsp_err, TIMEOUT);
            end
         end
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL to_early rsp=1 expected 0 before issue+%0d", TIMEOUT);
      end
      tick();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL to_idle busy=%b expected 0", busy);
      end
      tick();
      set_req(0, 3'b100, 8'h0F, 8'h11);
      req_valid = 4'b0001;
      wait_grant(g);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("FAIL to_next_grant got %b expected 0001", g);
      end
      sb.push_back('{id: 2'd0, res: 9'h0FF, err: 1'b0});
      tick();
      req_valid = '0;
      wait_alu(seen);
      checks++;
      if (!seen || alu_op !== 3'b100) begin
         errors++;
         $display("FAIL to_next_issue seen=%b op=%0h expected 1/4", seen, alu_op);
      end
      alu_complete(alu_model(3'b100, 8'h0F, 8'h11));
      wait_drain();
   endtask

   task automatic test_reset_mid_op();
      logic [3:0] g;
      bit         seen;
      tick();
      set_req(0, 3'b001, 8'h11, 8'h22);
      set_req(1, 3'b011, 8'h0C, 8'h0A);
      req_valid = 4'b0001;
      wait_grant(g);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("FAIL rmo_first_grant got %b expected 0001", g);
      end
      tick();
      req_valid = '0;
      wait_alu(seen);
      tick();
      req_valid = 4'b0011;
      rst       = 1'b1;
      #1;
      checks++;
      if (!seen || {req_grant, alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== '0) begin
         errors++;
         $display("FAIL rmo_outputs seen=%b grant=%b av=%b rv=%b busy=%b expected issue seen, all outputs 0",
                  seen, req_grant, alu_valid, rsp_valid, busy);
      end
      tick();
      rst = 1'b0;
      wait_grant(g);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("FAIL rmo_grant_after_reset got %b expected 0001", g);
      end
      sb.push_back('{id: 2'd0, res: 9'h033, err: 1'b0});
      tick();
      req_valid = '0;
      wait_alu(seen);
      alu_complete(alu_model(3'b001, 8'h11, 8'h22));
      wait_drain();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      alu_ready  = 1'b1;
      alu_done   = 1'b0;
      alu_result = '0;
      test_reset();
      test_round_robin();
      test_add_overflow();
      test_illegal_op();
      test_ready_stall();
      test_timeout();
      test_reset_mid_op();
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
